// File: rtl/rs_pkg.sv
// rs_pkg -- shared RS(31,19) definitions over GF(2^5).
// Contents:
//   SYM_W      symbol width (5 bits)
//   NPAR       parity symbol count (12)
//   PRIM_POLY  primitive polynomial x^5+x^2+1
//   G          generator coefficients g0..g11 of prod_{i=1..12}(x+alpha^i);
//              the x^12 term is 1 and is not stored
//   gf_mul     GF(2^5) multiply, used for constant products only
// The encoder and the decoder syndrome logic both use this package.
package rs_pkg;

    localparam int SYM_W = 5;
    localparam int NPAR  = 12;

    localparam logic [5:0]       PRIM_POLY = 6'b100101;
    // Only the low bits of the polynomial are used: they are the
    // reduction term applied when x^5 overflows.
    localparam logic [SYM_W-1:0] PRIM_RED  = PRIM_POLY[SYM_W-1:0];

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } enc_state_t;

    // Multiply MSB-first: double the partial result, then add a when the
    // current bit of b is set.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] r;
        r = 5'd0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            r = {r[SYM_W-2:0], 1'b0} ^ (r[SYM_W-1] ? PRIM_RED : 5'd0);
            if (b[i]) begin
                r = r ^ a;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Build the generator by multiplying in one (x + alpha^i) factor at a
    // time. Higher terms that are still zero do not change, so the inner
    // loop can always run over the full degree.
    function automatic logic [NPAR-1:0][SYM_W-1:0] gen_coeffs();
        logic [NPAR:0][SYM_W-1:0] g;
        logic [SYM_W-1:0]         root;
        g    = '0;
        g[0] = 5'd1;
        root = 5'd1;
        for (int i = 1; i <= NPAR; i++) begin
            root = gf_mul(root, 5'd2);
            for (int k = NPAR; k >= 1; k--) begin
                g[k] = g[k-1] ^ gf_mul(g[k], root);
            end
            g[0] = gf_mul(g[0], root);
        end
        return g[NPAR-1:0];
    endfunction

    localparam logic [NPAR-1:0][SYM_W-1:0] G = gen_coeffs();

endpackage

// File: rtl/gf_mult_const.sv
// gf_mult_const -- combinational GF(2^5) multiply by a constant coefficient.
// Parameters: COEF  constant multiplier
// Ports:      a     5-bit field element in
//             y     5-bit product a*COEF
module gf_mult_const
    import rs_pkg::*;
#(
    parameter logic [SYM_W-1:0] COEF = 5'd1
) (
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);

    // COEF is fixed, so this folds down to a small XOR network.
    assign y = gf_mul(a, COEF);

endmodule

// File: rtl/rs_encoder.sv
// rs_encoder -- systematic RS(31,19) encoder over GF(2^5).
// 19 message symbols pass straight through. They are followed by the 12
// parity symbols of m(x)*x^12 mod g(x), highest-order parity first.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_valid   datain holds a message symbol
//   in_ready   high in DATA; a symbol is accepted when in_valid is also high
//   datain     message symbol, highest-order symbol first
//   out_valid  dataout holds a codeword symbol (one cycle after it is produced)
//   out_sop    dataout is codeword symbol 0
//   out_eop    dataout is codeword symbol 30
//   dataout    registered codeword symbol
module rs_encoder
    import rs_pkg::*;
#(
    parameter int NSYM = 31,
    parameter int KSYM = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] datain,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [SYM_W-1:0] dataout
);

    if (NSYM != 31 || KSYM != 19) begin : g_bad_param
        $error("rs_encoder supports only NSYM=31, KSYM=19");
    end

    localparam logic [4:0] SYM_LAST = 5'd18;
    localparam logic [3:0] PAR_LAST = 4'd11;

    enc_state_t                   state_r,   state_s;
    logic [4:0]                   sym_cnt_r, sym_cnt_s;
    logic [3:0]                   par_cnt_r, par_cnt_s;
    logic [NPAR-1:0][SYM_W-1:0]   par_r,     par_s;
    logic [NPAR-1:0][SYM_W-1:0]   prod_s;
    logic [SYM_W-1:0]             fb_s;
    logic [SYM_W-1:0]             dout_s;
    logic                         valid_s, sop_s, eop_s;
    logic                         accept_s;

    assign in_ready = (state_r == ST_DATA);
    assign accept_s = in_valid & in_ready;
    assign fb_s     = datain ^ par_r[NPAR-1];

    // Twelve constant multipliers, one for each generator coefficient.
    for (genvar j = 0; j < NPAR; j++) begin : g_mult
        gf_mult_const #(.COEF(G[j])) u_mult (
            .a (fb_s),
            .y (prod_s[j])
        );
    end

    // Next state, LFSR update and next-output decode.
    always_comb begin
        state_s   = state_r;
        sym_cnt_s = sym_cnt_r;
        par_cnt_s = par_cnt_r;
        par_s     = par_r;
        dout_s    = dataout;
        valid_s   = 1'b0;
        sop_s     = 1'b0;
        eop_s     = 1'b0;
        case (state_r)
            ST_DATA: begin
                if (accept_s) begin
                    dout_s   = datain;
                    valid_s  = 1'b1;
                    sop_s    = (sym_cnt_r == 5'd0);
                    par_s[0] = prod_s[0];
                    for (int j = 1; j < NPAR; j++) begin
                        par_s[j] = par_r[j-1] ^ prod_s[j];
                    end
                    if (sym_cnt_r == SYM_LAST) begin
                        state_s   = ST_PARITY;
                        sym_cnt_s = 5'd0;
                    end else begin
                        sym_cnt_s = sym_cnt_r + 5'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                // Shift out the parity highest term first and fill with zeros,
                // so the register is clear once the last symbol has gone.
                dout_s   = par_r[NPAR-1];
                valid_s  = 1'b1;
                par_s[0] = 5'd0;
                for (int j = 1; j < NPAR; j++) begin
                    par_s[j] = par_r[j-1];
                end
                if (par_cnt_r == PAR_LAST) begin
                    state_s   = ST_DATA;
                    par_cnt_s = 4'd0;
                    eop_s     = 1'b1;
                end else begin
                    par_cnt_s = par_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s   = ST_DATA;
                sym_cnt_s = 5'd0;
                par_cnt_s = 4'd0;
                par_s     = '0;
            end
        endcase
    end

    // State, LFSR and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_DATA;
            sym_cnt_r <= 5'd0;
            par_cnt_r <= 4'd0;
            par_r     <= '0;
            dataout   <= 5'd0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            state_r   <= state_s;
            sym_cnt_r <= sym_cnt_s;
            par_cnt_r <= par_cnt_s;
            par_r     <= par_s;
            dataout   <= dout_s;
            out_valid <= valid_s;
            out_sop   <= sop_s;
            out_eop   <= eop_s;
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder -- self-checking bench for rs_encoder.
// The driver pushes each expected codeword (symbol + sop/eop) into a queue.
// The monitor pops one entry for every valid output. It also checks syndromes,
// the length of the in_ready-low run, and flag/reset behaviour.
module tb_rs_encoder;

    typedef logic [4:0] msg_t [19];
    typedef logic [4:0] cw_t  [31];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] datain = 5'd0;
    logic       in_ready, out_valid, out_sop, out_eop;
    logic [4:0] dataout;

    int n_checks = 0;
    int n_err    = 0;

    logic [6:0] exp_q [$];
    logic [4:0] gen [13];
    logic [4:0] cw_buf [31];
    logic [6:0] exp_e;
    int cw_idx = 0, vrun = 0, vrun_max = 0, rdy_run = 0, eop_sop_cnt = 0;
    logic prev_eop = 1'b0;

    always #5 clock = ~clock;

    rs_encoder #(.NSYM(31), .KSYM(19)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .dataout   (dataout)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // GF(2^5) multiply, LSB-first with an xtime of a on each step.
    function automatic logic [4:0] mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r, x, y;
        r = 5'd0; x = a; y = b;
        for (int i = 0; i < 5; i++) begin
            if (y[0]) r = r ^ x;
            x = x[4] ? ({x[3:0], 1'b0} ^ 5'b00101) : {x[3:0], 1'b0};
            y = y >> 1;
        end
        return r;
    endfunction

    // Long division of m(x)*x^12 by g(x) over the full 31-coefficient array.
    task automatic encode(input msg_t m, output cw_t c_o);
        logic [4:0] c [31];
        logic [4:0] q;
        for (int p = 0; p < 31; p++) c[p] = 5'd0;
        for (int i = 0; i < 19; i++) c[30-i] = m[i];
        for (int p = 30; p >= 12; p--) begin
            q = c[p];
            for (int k = 0; k <= 12; k++) c[p-12+k] = c[p-12+k] ^ mul(q, gen[k]);
        end
        for (int n = 0; n < 19; n++) c_o[n] = m[n];
        for (int n = 19; n < 31; n++) c_o[n] = c[30-n];
    endtask

    // Syndrome at alpha^i. Symbol n is the coefficient of x^(30-n).
    function automatic logic [4:0] syndrome(input cw_t c, input int i);
        logic [4:0] ai, s;
        ai = 5'd1;
        for (int k = 0; k < i; k++) ai = mul(ai, 5'd2);
        s = 5'd0;
        for (int n = 0; n < 31; n++) s = mul(s, ai) ^ c[n];
        return s;
    endfunction

    task automatic send_msg(input msg_t m, input cw_t c, input int gap_pct, input bit toggle);
        int  i = 0;
        int  budget = 0;
        bit  rdy, v;
        for (int n = 0; n < 31; n++) exp_q.push_back({(n == 0), (n == 30), c[n]});
        while (i < 19 && budget < 2000) begin
            @(negedge clock);
            budget++;
            rdy = in_ready;
            if (!rdy && toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                datain   = 5'($urandom_range(0, 31));
            end else begin
                v        = ($urandom_range(0, 99) >= gap_pct);
                in_valid = v;
                datain   = v ? m[i] : 5'($urandom_range(0, 31));
            end
            @(posedge clock);
            if (in_valid && rdy) i++;
        end
        chk("send_accepts", i, 19);
    endtask

    // Idle cycles. With rnd set, in_valid and datain are randomised while
    // in_ready is low, so the encoder never accepts a garbage symbol.
    task automatic idle(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clock);
            if (rnd && !in_ready) begin
                in_valid = 1'($urandom_range(0, 1));
                datain   = 5'($urandom_range(0, 31));
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic rand_msg(output msg_t m);
        for (int i = 0; i < 19; i++) m[i] = 5'($urandom_range(0, 31));
    endtask

    // Monitor: scoreboard compare, syndromes, run lengths and reset outputs.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_flags", {out_sop, out_eop}, 0);
            chk("rst_data", dataout, 0);
            chk("rst_ready", in_ready, 1);
            exp_q.delete();
            cw_idx = 0; vrun = 0; rdy_run = 0; prev_eop = 1'b0;
        end else begin
            if (out_valid) begin
                vrun++;
                if (vrun > vrun_max) vrun_max = vrun;
                if (out_sop) begin
                    cw_idx = 0;
                    if (prev_eop) eop_sop_cnt++;
                end
                if (cw_idx < 31) cw_buf[cw_idx] = dataout;
                cw_idx++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("cw_sym", {out_sop, out_eop, dataout}, exp_e);
                end
                if (out_eop) begin
                    chk("cw_len", cw_idx, 31);
                    if (cw_idx == 31) begin
                        for (int i = 1; i <= 12; i++) chk("syndrome", syndrome(cw_buf, i), 0);
                    end
                end
            end else begin
                vrun = 0;
                chk("idle_flags", {out_sop, out_eop}, 0);
            end
            prev_eop = out_valid & out_eop;
            if (!in_ready) begin
                rdy_run++;
            end else if (rdy_run != 0) begin
                chk("ready_low_len", rdy_run, 12);
                rdy_run = 0;
            end
        end
    end

    initial begin
        msg_t m, m2;
        cw_t  c, c2;
        int   w;

        // Generator polynomial, built factor by factor.
        for (int k = 0; k < 13; k++) gen[k] = 5'd0;
        gen[0] = 5'd1;
        begin
            logic [4:0] root;
            root = 5'd1;
            for (int i = 1; i <= 12; i++) begin
                root = mul(root, 5'd2);
                for (int k = 12; k >= 1; k--) gen[k] = gen[k-1] ^ mul(gen[k], root);
                gen[0] = mul(gen[0], root);
            end
        end

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // All-zero message: 31 contiguous zero outputs.
        vrun_max = 0;
        for (int i = 0; i < 19; i++) m[i] = 5'd0;
        for (int n = 0; n < 31; n++) c[n] = 5'd0;
        send_msg(m, c, 0, 1'b0);
        idle(20, 1'b0);
        chk("zero_run", vrun_max, 31);

        // Impulse in the last message symbol: the parity is g11..g0.
        m[18] = 5'd1;
        for (int n = 0; n < 31; n++) c[n] = 5'd0;
        c[18] = 5'd1;
        for (int k = 0; k < 12; k++) c[19+k] = gen[11-k];
        send_msg(m, c, 0, 1'b0);
        idle(20, 1'b0);

        // 100 random messages with random gaps on in_valid.
        for (int t = 0; t < 100; t++) begin
            rand_msg(m);
            encode(m, c);
            send_msg(m, c, 30, 1'b0);
        end
        idle(20, 1'b0);

        // The same message without and with toggling inputs during parity.
        rand_msg(m);
        encode(m, c);
        send_msg(m, c, 0, 1'b0);
        idle(20, 1'b0);
        send_msg(m, c, 0, 1'b1);
        send_msg(m, c, 0, 1'b1);
        idle(20, 1'b1);

        // Reset during parity symbol 5, then a clean codeword.
        rand_msg(m);
        encode(m, c);
        send_msg(m, c, 0, 1'b0);
        idle(5, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rand_msg(m);
        encode(m, c);
        send_msg(m, c, 10, 1'b0);
        idle(20, 1'b0);

        // Two messages back to back with in_valid held high.
        vrun_max = 0;
        eop_sop_cnt = 0;
        rand_msg(m);
        encode(m, c);
        rand_msg(m2);
        encode(m2, c2);
        send_msg(m, c, 0, 1'b0);
        send_msg(m2, c2, 0, 1'b0);
        idle(20, 1'b0);
        chk("b2b_run", vrun_max, 62);
        chk("b2b_eop_sop", eop_sop_cnt, 1);

        // Drain any outstanding expected symbols.
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        chk("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 The block SHALL have parameter NSYM, default 31, codeword length in symbols; only 31 is supported, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter KSYM, default 19, message length in symbols; only 19 is supported (NSYM-KSYM = 12 parity), and any other value SHALL fail elaboration.
REQ-003 Port clock SHALL be an input, 1 bit wide: the single clock, with all state on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: reset is synchronous and active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: datain holds a message symbol.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the encoder accepts a symbol this cycle.
REQ-007 Port datain SHALL be an input, 5 bits wide: message symbol in GF(2^5), highest-order symbol first.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: dataout holds a codeword symbol.
REQ-009 Port out_sop SHALL be an output, 1 bit wide: dataout is codeword symbol 0.
REQ-010 Port out_eop SHALL be an output, 1 bit wide: dataout is codeword symbol 30 (the last parity symbol).
REQ-011 Port dataout SHALL be an output, 5 bits wide: codeword symbol, registered.

Function
REQ-012 The encoder SHALL be systematic RS(31,19) over GF(2^5), primitive polynomial x^5+x^2+1, with generator g(x)=prod_{i=1..12}(x+alpha^i) and the codeword = 19 message symbols followed by 12 parity symbols (remainder of m(x)*x^12 mod g(x)).
REQ-013 The state machine SHALL have two states: DATA (in_ready=1) and PARITY (in_ready=0).
REQ-014 An accept SHALL be the condition in_valid&in_ready; in DATA, each accept SHALL increment sym_cnt (0..18).
REQ-015 An accept with sym_cnt=18 SHALL move to PARITY and clear sym_cnt.
REQ-016 The LFSR SHALL hold 12x5-bit parity registers par[0..11]; on each accept: fb = datain XOR par[11], par[0] <= g0*fb, and par[j] <= par[j-1] XOR gj*fb for j = 1..11.
REQ-017 Data latency SHALL be one cycle: the cycle after an accept, out_valid=1 and dataout = the accepted datain.
REQ-018 A cycle without an accept in DATA SHALL give out_valid=0 the next cycle; out_valid SHALL NOT be held and there is no output backpressure.
REQ-019 PARITY SHALL last exactly 12 cycles, counted by par_cnt (0..11).
REQ-020 In each PARITY cycle, dataout SHALL be loaded with par[11], par[j] <= par[j-1], and par[0] <= 0, with out_valid=1 the following cycle.
REQ-021 The PARITY cycle with par_cnt=11 SHALL return the state machine to DATA with all par registers and par_cnt equal to 0.
REQ-022 out_sop SHALL be 1 with the output of the accept made at sym_cnt=0.
REQ-023 out_eop SHALL be 1 with the output of the par_cnt=11 cycle.
REQ-024 out_sop and out_eop SHALL be 0 whenever out_valid=0.
REQ-025 Back-to-back codewords SHALL produce no output bubbles: the last data symbol, 12 parity symbols, and the next codeword's first symbol SHALL be contiguous when in_valid is held high.
REQ-026 in_valid and datain during PARITY SHALL be ignored and SHALL NOT change any state.
REQ-027 All GF multiplications SHALL be by constant coefficients and purely combinational; GF addition SHALL be XOR; all values SHALL remain 5 bits wide.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL become DATA, sym_cnt=par_cnt=0, all par registers SHALL be 0, and dataout=0, out_valid=0, out_sop=0, out_eop=0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is deasserted.
REQ-030 Reset asserted mid-message or mid-parity SHALL abandon the codeword with no partial eop, and the next accept SHALL start a new codeword (out_sop=1).

Structure
REQ-031 A shared package rs_pkg SHALL hold SYM_W=5, the primitive polynomial constant, and generator coefficients G[0..11]; it is also used by the decoder syndrome logic.
REQ-032 One sub-module gf_mult_const (5-bit input, constant-parameter GF(2^5) multiplier) SHALL be instantiated 12 times.
REQ-033 The block SHALL contain no other hierarchy.

Verification
REQ-034 The bench SHALL apply 19 zero symbols with in_valid held high and check that 31 contiguous zero outputs follow, with sop on symbol 0, eop on symbol 30, and in_ready=0 for exactly 12 cycles.
REQ-035 The bench SHALL apply 18 zeros then 5'd1 and check that the parity output equals G[11], G[10], ..., G[0] in order.
REQ-036 The bench SHALL apply 100 random messages with random in_valid gaps, check that every codeword evaluated at alpha^1..alpha^12 gives all-zero syndromes, and check that the data symbols match the inputs.
REQ-037 The bench SHALL toggle in_valid and datain randomly during PARITY and check that the output is identical to the run without toggling.
REQ-038 The bench SHALL assert reset at parity symbol 5 and check out_valid=0 the next cycle, then encode a full codeword and check that it matches the golden model.
REQ-039 The bench SHALL run two back-to-back messages and check that out_valid=1 for 62 consecutive cycles and the second out_sop follows the first out_eop immediately.
